// File: rtl/z80_shared_ram_arbiter.sv
// Shares one single-port synchronous work RAM between the Z80 bus and a DMA
// requester; the CPU is stalled through WAIT_N and ties alternate round robin.
module z80_shared_ram_arbiter #(
    parameter int unsigned ADDR_W   = 10,
    parameter logic [15:0] WIN_BASE = 16'h6000,
    parameter logic [15:0] WIN_MASK = 16'hFC00
) (
    input  logic              CLK,
    input  logic              RESET_N,
    input  logic [15:0]       CPU_ADRS,
    input  logic [7:0]        CPU_DOUT,
    input  logic              CPU_MREQ_N,
    input  logic              CPU_RD_N,
    input  logic              CPU_WR_N,
    input  logic              CPU_RFSH_N,
    output logic              CPU_WAIT_N,
    output logic [7:0]        CPU_DINP,
    input  logic              DMA_REQ,
    input  logic              DMA_WE,
    input  logic [ADDR_W-1:0] DMA_ADRS,
    input  logic [7:0]        DMA_WDATA,
    output logic              DMA_ACK,
    output logic [7:0]        DMA_RDATA,
    output logic [ADDR_W-1:0] RAM_ADRS,
    output logic              RAM_WE,
    output logic [7:0]        RAM_WDATA,
    input  logic [7:0]        RAM_RDATA
);

    typedef enum logic [2:0] {
        IDLE,
        CPU_ACC,
        CPU_FIN,
        DMA_ACC,
        DMA_FIN
    } state_t;

    state_t state;
    state_t state_nx;

    logic win_hit;
    logic cpu_req;
    logic cpu_done;
    logic cpu_rd_acc;
    logic last_grant_cpu;
    logic grant_cpu;
    logic grant_dma;

    assign win_hit = ((CPU_ADRS & WIN_MASK) == WIN_BASE);

    // cpu_done masks the request after completion so one bus cycle makes one RAM access.
    always_comb begin
        cpu_req = ~CPU_MREQ_N & CPU_RFSH_N & (~CPU_RD_N | ~CPU_WR_N) & win_hit & ~cpu_done;
    end

    always_comb begin
        grant_cpu = 1'b0;
        grant_dma = 1'b0;
        if (state == IDLE) begin
            if (cpu_req && DMA_REQ) begin
                grant_cpu = ~last_grant_cpu;
                grant_dma = last_grant_cpu;
            end else begin
                grant_cpu = cpu_req;
                grant_dma = DMA_REQ;
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (!RESET_N) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE: begin
                if (grant_cpu) begin
                    state_nx = CPU_ACC;
                end else if (grant_dma) begin
                    state_nx = DMA_ACC;
                end
            end
            CPU_ACC: state_nx = CPU_FIN;
            CPU_FIN: state_nx = IDLE;
            DMA_ACC: state_nx = DMA_FIN;
            DMA_FIN: state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_comb begin
        CPU_WAIT_N = RESET_N ? ~cpu_req : 1'b1;
    end

    // MREQ_N high clears cpu_done even on the completion edge itself.
    always_ff @(posedge CLK) begin
        if (!RESET_N) begin
            RAM_WE         <= 1'b0;
            RAM_ADRS       <= '0;
            RAM_WDATA      <= '0;
            CPU_DINP       <= 8'hFF;
            DMA_ACK        <= 1'b0;
            DMA_RDATA      <= '0;
            cpu_done       <= 1'b0;
            cpu_rd_acc     <= 1'b0;
            last_grant_cpu <= 1'b0;
        end else begin
            DMA_ACK <= 1'b0;
            case (state)
                IDLE: begin
                    if (grant_cpu) begin
                        RAM_ADRS   <= CPU_ADRS[ADDR_W-1:0];
                        RAM_WDATA  <= CPU_DOUT;
                        RAM_WE     <= ~CPU_WR_N;
                        cpu_rd_acc <= CPU_WR_N;
                    end else if (grant_dma) begin
                        RAM_ADRS  <= DMA_ADRS;
                        RAM_WDATA <= DMA_WDATA;
                        RAM_WE    <= DMA_WE;
                    end
                end
                CPU_ACC, DMA_ACC: begin
                    RAM_WE <= 1'b0;
                end
                CPU_FIN: begin
                    if (cpu_rd_acc) begin
                        CPU_DINP <= RAM_RDATA;
                    end
                    cpu_done       <= 1'b1;
                    last_grant_cpu <= 1'b1;
                end
                DMA_FIN: begin
                    DMA_RDATA      <= RAM_RDATA;
                    DMA_ACK        <= 1'b1;
                    last_grant_cpu <= 1'b0;
                end
                default: ;
            endcase
            if (CPU_MREQ_N) begin
                cpu_done <= 1'b0;
            end
        end
    end

endmodule
